// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues FPU commands in a DEPTH-entry FIFO and issues them
// one at a time to a downstream registered FPU. Each result is captured and
// presented on a valid/ready output handshake before the next command issues.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   in_valid/in_ready           command handshake
//   in_A, in_B, in_sel,
//   in_round_mode               command payload (sel: 00 add, 01 sub, 10 mul, 11 div)
//   fpu_A, fpu_B, fpu_sel,
//   fpu_round_mode, fpu_start   drive to the FPU; nonzero only in ISSUE
//   fpu_Y, fpu_error,
//   fpu_overflow                registered FPU results
//   out_valid/out_ready         result handshake
//   out_Y, out_error,
//   out_overflow, out_sel       result payload
//   busy, count                 FSM not idle; FIFO occupancy
//   err_count, ovf_count        saturating error/overflow counters
//
// Optional feature: define FPU_ISSUE_STATS_EN to enable err_count/ovf_count.
// Without it both ports are tied to zero.
module fpu_issue_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_A,
  input  logic [31:0]            in_B,
  input  logic [1:0]             in_sel,
  input  logic [1:0]             in_round_mode,
  output logic [31:0]            fpu_A,
  output logic [31:0]            fpu_B,
  output logic [1:0]             fpu_sel,
  output logic [1:0]             fpu_round_mode,
  output logic                   fpu_start,
  input  logic [31:0]            fpu_Y,
  input  logic                   fpu_error,
  input  logic                   fpu_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_Y,
  output logic                   out_error,
  output logic                   out_overflow,
  output logic [1:0]             out_sel,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            err_count,
  output logic [15:0]            ovf_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
    logic [1:0]  rm;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  cmd_t               r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_push;
  logic               w_pop;
  logic               w_capture;
  logic               w_resp_done;
  cmd_t               w_head;
  cmd_t               w_in_cmd;
  logic [1:0]         r_iss_sel;
  logic               r_out_valid;
  logic [31:0]        r_out_Y;
  logic               r_out_error;
  logic               r_out_overflow;
  logic [1:0]         r_out_sel;

  // FIFO handshake; full blocks a push even when a pop happens the same cycle
  assign in_ready    = (r_count < CNT_W'(DEPTH)) && !reset;
  assign w_push      = in_valid && in_ready;
  assign w_pop       = (r_state == ISSUE);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_in_cmd    = '{a: in_A, b: in_B, sel: in_sel, rm: in_round_mode};

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_cmd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and FPU drive; occupancy decisions use the post-edge count so
  // a command pushed into an empty FIFO issues on the following cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_resp_done    = 1'b0;
    fpu_A          = '0;
    fpu_B          = '0;
    fpu_sel        = '0;
    fpu_round_mode = '0;
    fpu_start      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        fpu_A          = w_head.a;
        fpu_B          = w_head.b;
        fpu_sel        = w_head.sel;
        fpu_round_mode = w_head.rm;
        fpu_start      = 1'b1;
        w_state_nxt    = WAIT;
      end
      WAIT: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (out_ready) begin
          w_resp_done = 1'b1;
          w_state_nxt = (w_count_nxt != '0) ? ISSUE : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result capture; payload holds its last value while out_valid is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_iss_sel      <= '0;
      r_out_valid    <= 1'b0;
      r_out_Y        <= '0;
      r_out_error    <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_sel      <= '0;
    end else begin
      if (w_pop) r_iss_sel <= w_head.sel;
      if (w_capture) begin
        r_out_valid    <= 1'b1;
        r_out_Y        <= fpu_Y;
        r_out_error    <= fpu_error;
        r_out_overflow <= fpu_overflow;
        r_out_sel      <= r_iss_sel;
      end else if (w_resp_done) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_Y        = r_out_Y;
  assign out_error    = r_out_error;
  assign out_overflow = r_out_overflow;
  assign out_sel      = r_out_sel;
  assign busy         = (r_state != IDLE);
  assign count        = r_count;

`ifdef FPU_ISSUE_STATS_EN
  logic [15:0] r_err_cnt;
  logic [15:0] r_ovf_cnt;

  // Saturating event counters, bumped on the result-capture edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
      r_ovf_cnt <= '0;
    end else if (w_capture) begin
      if (fpu_error && (r_err_cnt != 16'hFFFF))    r_err_cnt <= r_err_cnt + 16'd1;
      if (fpu_overflow && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign err_count = r_err_cnt;
  assign ovf_count = r_ovf_cnt;
`else
  assign err_count = '0;
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed self-checking bench for fpu_issue_ctrl (DEPTH=4)
// with a behavioural registered FPU and an in-order result scoreboard.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_A, in_B;
  logic [1:0]  in_sel, in_round_mode;
  logic [31:0] fpu_A, fpu_B;
  logic [1:0]  fpu_sel, fpu_round_mode;
  logic        fpu_start;
  logic [31:0] fpu_Y = '0;
  logic        fpu_error = 1'b0;
  logic        fpu_overflow = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_Y;
  logic        out_error, out_overflow;
  logic [1:0]  out_sel;
  logic        busy;
  logic [2:0]  count;
  logic [15:0] err_count, ovf_count;

  typedef struct packed {
    logic [31:0] y;
    logic        err;
    logic        ovf;
    logic [1:0]  sel;
  } res_t;

  res_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_sel(in_sel), .in_round_mode(in_round_mode),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_sel(fpu_sel),
    .fpu_round_mode(fpu_round_mode), .fpu_start(fpu_start),
    .fpu_Y(fpu_Y), .fpu_error(fpu_error), .fpu_overflow(fpu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Y(out_Y), .out_error(out_error), .out_overflow(out_overflow),
    .out_sel(out_sel), .busy(busy), .count(count),
    .err_count(err_count), .ovf_count(ovf_count)
  );

  // Stand-in FPU arithmetic: exact for 1.0+2.0, a scrambling function otherwise
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] s, input logic [1:0] rm);
    res_t r;
    if (s == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) r.y = 32'h40400000;
    else r.y = a ^ {b[30:0], b[31]} ^ {s, rm, 28'h0};
    r.err = (s == 2'b11) && (b[30:0] == 31'h0);
    r.ovf = (s == 2'b10) && (a[30:23] == 8'hFE);
    r.sel = s;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Registered FPU: result appears the edge after fpu_start
  always @(posedge clk) begin : fpu_model
    res_t m;
    if (fpu_start) begin
      m = model(fpu_A, fpu_B, fpu_sel, fpu_round_mode);
      fpu_Y        <= m.y;
      fpu_error    <= m.err;
      fpu_overflow <= m.ovf;
    end
  end

  // Scoreboard: sampled at negedge, the handshake completes on the next edge
  always @(negedge clk) begin : monitor
    res_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_Y", out_Y, e.y);
        check("res_err", 32'(out_error), 32'(e.err));
        check("res_ovf", 32'(out_overflow), 32'(e.ovf));
        check("res_sel", 32'(out_sel), 32'(e.sel));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] s, input logic [1:0] rm);
    int n;
    n = 0;
    in_valid = 1'b1; in_A = a; in_B = b; in_sel = s; in_round_mode = rm;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(model(a, b, s, rm));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    res_t exp0;
    reset = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0;
    in_sel = '0; in_round_mode = '0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_Y", out_Y, 32'd0);
    check("rst_fpu_start", 32'(fpu_start), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Single add: 1.0 + 2.0, out_valid three edges after acceptance
    push(32'h3F800000, 32'h40000000, 2'b00, 2'b00);
    check("add_e1_start", 32'(fpu_start), 32'd1);
    check("add_e1_fpuA", fpu_A, 32'h3F800000);
    check("add_e1_fpuB", fpu_B, 32'h40000000);
    check("add_e1_busy", 32'(busy), 32'd1);
    check("add_e1_valid", 32'(out_valid), 32'd0);
    tick();
    check("add_e2_start", 32'(fpu_start), 32'd0);
    check("add_e2_fpuA", fpu_A, 32'd0);
    check("add_e2_valid", 32'(out_valid), 32'd0);
    tick();
    check("add_e3_valid", 32'(out_valid), 32'd1);
    check("add_e3_Y", out_Y, 32'h40400000);
    check("add_e3_sel", 32'(out_sel), 32'd0);
    check("add_e3_err", 32'(out_error), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_done_valid", 32'(out_valid), 32'd0);
    check("add_done_busy", 32'(busy), 32'd0);
    check("add_hold_Y", out_Y, 32'h40400000);
    check("add_q_empty", 32'(exp_q.size()), 32'd0);

    // Fill with out_ready low: five pushes leave four queued and in_ready low
    exp0 = model(32'h11111111, 32'h22222222, 2'b01, 2'b01);
    push(32'h11111111, 32'h22222222, 2'b01, 2'b01);
    push(32'h33333333, 32'h44444444, 2'b10, 2'b10);
    push(32'h55555555, 32'h66666666, 2'b11, 2'b11);
    push(32'h77777777, 32'h88888888, 2'b00, 2'b00);
    push(32'h99999999, 32'hAAAAAAAA, 2'b01, 2'b10);
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);

    // Backpressure in RESP with a pending (rejected) push while full
    in_valid = 1'b1; in_A = 32'hDEADBEEF; in_B = 32'h0; in_sel = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_Y", out_Y, exp0.y);
      check("bp_start", 32'(fpu_start), 32'd0);
      check("bp_count", 32'(count), 32'd4);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();
    check("fill_idle", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // Reset during WAIT with three commands queued
    push(32'h01010101, 32'h02020202, 2'b00, 2'b00);
    push(32'h03030303, 32'h04040404, 2'b01, 2'b00);
    push(32'h05050505, 32'h06060606, 2'b10, 2'b00);
    push(32'h07070707, 32'h08080808, 2'b11, 2'b00);
    out_ready = 1'b1;
    push(32'h09090909, 32'h0A0A0A0A, 2'b00, 2'b01);
    tick();
    check("wait_count", 32'(count), 32'd3);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_start", 32'(fpu_start), 32'd0);
    check("wait_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_Y", out_Y, 32'd0);
    check("mid_rst_out_sel", 32'(out_sel), 32'd0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Stream of 20 mixed operations with random out_ready (pointers wrap)
    rnd_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push($urandom, $urandom, 2'(i % 4), 2'((i / 4) % 4));
    end
    drain();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    check("stream_count", 32'(count), 32'd0);
    check("stream_idle", 32'(busy), 32'd0);

    // Statistics: three divides by zero after a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) push(32'h3F800000, 32'h00000000, 2'b11, 2'b00);
    drain();
`ifdef FPU_ISSUE_STATS_EN
    check("stats_err_count", 32'(err_count), 32'd3);
`else
    check("stats_err_count", 32'(err_count), 32'd0);
`endif
    check("stats_ovf_count", 32'(ovf_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of command FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the command handshake.
REQ-005 SHALL have ports in_A and in_B (input, 32 each), the IEEE-754 single-precision operands.
REQ-006 SHALL have ports in_sel (input, 2; 00 add, 01 sub, 10 mul, 11 div) and in_round_mode (input, 2).
REQ-007 SHALL have ports fpu_A, fpu_B (output, 32), fpu_sel, fpu_round_mode (output, 2) and fpu_start (output, 1), which drive the downstream registered FPU.
REQ-008 SHALL have ports fpu_Y (input, 32), fpu_error and fpu_overflow (input, 1 each), the FPU's registered results.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-010 SHALL have ports out_Y (output, 32), out_error, out_overflow (output, 1) and out_sel (output, 2), the result payload.
REQ-011 SHALL have ports busy (output, 1; state != IDLE) and count (output, clog2(DEPTH)+1; FIFO occupancy).

Function
REQ-012 SHALL buffer commands {A,B,sel,round_mode} in a DEPTH-entry FIFO; push on in_valid && in_ready, with in_ready = (count < DEPTH) && !reset.
REQ-013 SHALL not push when full, even in a cycle that also pops.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-015 SHALL transition IDLE -> ISSUE on the edge where count != 0.
REQ-016 SHALL, in ISSUE, hold fpu_start=1 for exactly one cycle, drive fpu_* from the FIFO head, pop the head on that cycle's closing edge, and go to WAIT.
REQ-017 SHALL drive fpu_A, fpu_B, fpu_sel and fpu_round_mode to 0 and fpu_start to 0 in every state other than ISSUE.
REQ-018 SHALL, in WAIT, register fpu_Y, fpu_error, fpu_overflow and the issued sel into out_Y, out_error, out_overflow and out_sel, set out_valid, and go to RESP.
REQ-019 SHALL, in RESP, hold out_valid=1 with stable payload until out_ready=1; on that edge clear out_valid and go to ISSUE if count != 0 (counted after any same-edge push), otherwise to IDLE.
REQ-020 SHALL give a latency of 3 edges from command acceptance (empty FIFO, IDLE) to out_valid=1, and a throughput of at most one command per 3 cycles.
REQ-021 SHALL return results in command acceptance order, with no drops and no duplicates.
REQ-022 SHALL accept pushes in every state, including concurrently with a pop.
REQ-023 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-024 SHALL hold out_Y, out_error, out_overflow and out_sel at their last values while out_valid=0.

Reset
REQ-025 SHALL, while reset=1, force state=IDLE, count=0, pointers=0, out_valid=0, out_Y=0, out_error=0, out_overflow=0, out_sel=0, fpu_start=0, in_ready=0, busy=0.
REQ-026 SHALL, on reset asserted mid-operation, discard all queued and in-flight commands; no out_valid results from any of them.

Configuration
REQ-027 SHALL, with macro FPU_ISSUE_STATS_EN defined, add outputs err_count and ovf_count (16 bits each, reset 0), each incrementing on the WAIT-capture edge when fpu_error (resp. fpu_overflow) is 1, saturating at 0xFFFF.
REQ-028 SHALL, without FPU_ISSUE_STATS_EN, keep the ports present, tie them to constant 0, and instantiate no counter logic.

Verification
REQ-029 Single add: push A=0x3F800000, B=0x40000000, sel=00, with an FPU model returning 0x40400000 -> out_valid 3 edges after acceptance, out_Y=0x40400000, out_sel=00, error=0.
REQ-030 Fill: push 5 commands with DEPTH=4 and out_ready=0 -> in_ready=0 once count reaches 4; 5th command accepted only after the first pop.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in RESP -> out_Y stable, fpu_start=0 throughout, no second issue.
REQ-032 Ordering/wrap: stream 20 mixed add/sub/mul/div commands with random out_ready -> 20 results in order, pointers wrap cleanly.
REQ-033 Reset mid-op: assert reset during WAIT with 3 commands queued -> all outputs return to reset values immediately; no out_valid after release until a new push.
REQ-034 Stats (FPU_ISSUE_STATS_EN): 3 divides by zero, with the model asserting fpu_error -> err_count=3; otherwise err_count=0.
